// File: rtl/nor_tree_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined NOR tree.
package nor_tree_pkg;

  localparam int TOGGLE_W = 16;
  localparam logic [TOGGLE_W-1:0] TOGGLE_SAT = 16'hFFFF;

  // Number of tree levels, never less than one (NIN=1 still gets a register).
  function automatic int clog_fanin(input int nin, input int fanin);
    int n = nin;
    int l = 0;
    while (n > 1) begin
      n = (n + fanin - 1) / fanin;
      l++;
    end
    return (l < 1) ? 1 : l;
  endfunction

  // Node count produced by level lvl (level 0 reduces the raw operands).
  function automatic int nodes_at(input int nin, input int fanin, input int lvl);
    int n = nin;
    for (int i = 0; i <= lvl; i++) n = (n + fanin - 1) / fanin;
    return n;
  endfunction

endpackage

// File: rtl/nor_tree_stage.sv
// One OR level of the tree: groups FANIN operands per node, registers the
// result with its own valid bit; INV stores the inverted result (output level).
module nor_tree_stage
  import nor_tree_pkg::*;
#(
  parameter int NI    = 3,
  parameter int NO    = 1,
  parameter int W     = 1,
  parameter int FANIN = 3,
  parameter bit INV   = 1'b0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NI*W-1:0] din,
  input  logic            din_valid,
  input  logic            next_adv,
  output logic            adv,
  output logic [NO*W-1:0] q,
  output logic            q_valid
);

  localparam int PW = NO * FANIN * W;

  logic [PW-1:0]   din_pad;
  logic [NO*W-1:0] or_nxt;

  // Zero padding supplies the missing operands of the last node.
  assign din_pad = PW'(din);

  always_comb begin
    or_nxt = '0;
    for (int j = 0; j < NO; j++)
      for (int f = 0; f < FANIN; f++)
        or_nxt[j*W +: W] = or_nxt[j*W +: W] | din_pad[(j*FANIN+f)*W +: W];
  end

  assign adv = !q_valid || next_adv;

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_valid <= 1'b0;
      q       <= INV ? {(NO*W){1'b1}} : '0;
    end else if (adv) begin
      q_valid <= din_valid;
      if (din_valid) q <= INV ? ~or_nxt : or_nxt;
    end
  end

endmodule

// File: rtl/nor_tree_pipe.sv
// Pipelined NIN-input bitwise NOR tree with valid/ready flow control.
// Define NOR_TREE_TOGGLE_CNT_EN to add the QN[0] toggle counter port.
module nor_tree_pipe
  import nor_tree_pkg::*;
#(
  parameter int NIN   = 3,
  parameter int W     = 1,
  parameter int FANIN = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NIN*W-1:0] IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [W-1:0]     QN,
  output logic             OUT_VALID,
  input  logic             OUT_READY
`ifdef NOR_TREE_TOGGLE_CNT_EN
  ,
  output logic [TOGGLE_W-1:0] TOGGLE_CNT
`endif
);

  localparam int L = clog_fanin(NIN, FANIN);

  logic [L:0] vld_pipe;

  assign vld_pipe[0] = IN_VALID;

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int NI = (k == 0) ? NIN : nodes_at(NIN, FANIN, k - 1);
    localparam int NO = nodes_at(NIN, FANIN, k);

    logic [NI*W-1:0] d;
    logic [NO*W-1:0] q;
    logic            adv;
    logic            next_adv;

    if (k == 0) begin : g_src
      assign d = IN;
    end else begin : g_src
      assign d = g_lvl[k-1].q;
    end

    // Backpressure ripples from the output toward the input combinationally.
    if (k == L - 1) begin : g_nxt
      assign next_adv = !OUT_VALID || OUT_READY;
    end else begin : g_nxt
      assign next_adv = g_lvl[k+1].adv;
    end

    nor_tree_stage #(
      .NI(NI), .NO(NO), .W(W), .FANIN(FANIN), .INV(k == L - 1)
    ) u_stage (
      .CLK      (CLK),
      .RST      (RST),
      .din      (d),
      .din_valid(vld_pipe[k]),
      .next_adv (next_adv),
      .adv      (adv),
      .q        (q),
      .q_valid  (vld_pipe[k+1])
    );
  end

  assign IN_READY  = g_lvl[0].adv;
  assign OUT_VALID = vld_pipe[L];
  assign QN        = g_lvl[L-1].q;

`ifdef NOR_TREE_TOGGLE_CNT_EN
  logic                prev_q0;
  logic [TOGGLE_W-1:0] tcnt;

  // prev_q0 resets to 1 so the first consumed word compares against 1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q0 <= 1'b1;
      tcnt    <= '0;
    end else if (OUT_VALID && OUT_READY) begin
      prev_q0 <= QN[0];
      if (QN[0] != prev_q0 && tcnt != TOGGLE_SAT) tcnt <= tcnt + 1'b1;
    end
  end

  assign TOGGLE_CNT = tcnt;
`else
  // Toggle counter not built in this configuration.
`endif

endmodule
